// File: rtl/vector_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : vector_reg_file_sb
// Brief    : Vector register file with lane-masked writes, forwarding,
//            RAW pending scoreboard and a sequenced bulk-clear engine.
// Revision : 1.0
// ============================================================================
module vector_reg_file_sb #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_SIZE  = 6,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDRESSWIDTH-1:0]           ra1,
    input  logic [ADDRESSWIDTH-1:0]           ra2,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] rd1,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] rd2,
    output logic                              busy1,
    output logic                              busy2,
    input  logic                              we3,
    input  logic [ADDRESSWIDTH-1:0]           wa3,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] wd3,
    input  logic [VECTOR_SIZE-1:0]            wm3,
    input  logic                              iss_valid,
    input  logic [ADDRESSWIDTH-1:0]           iss_rd,
    input  logic                              clr_req,
    output logic                              clr_busy,
    output logic                              clr_done
);

    localparam int                    c_VW      = VECTOR_SIZE * DATA_WIDTH;
    localparam logic [ADDRESSWIDTH:0] c_REGNUM  = (ADDRESSWIDTH+1)'(REGNUM);
    localparam logic [ADDRESSWIDTH-1:0] c_LAST  = ADDRESSWIDTH'(REGNUM - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRESSWIDTH-1:0] r_cnt;
    logic [ADDRESSWIDTH-1:0] w_cnt_nxt;
    logic                    r_done;
    logic                    w_done_nxt;

    logic [c_VW-1:0]         r_mem [REGNUM];
    logic [REGNUM-1:0]       r_pending;

    logic                    w_idle;
    logic                    w_wr_ok;
    logic                    w_iss_ok;
    logic [ADDRESSWIDTH-1:0] w_ra [2];
    logic [1:0][c_VW-1:0]    w_rd;
    logic [1:0]              w_busy;

    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_ok  = we3 & w_idle & ({1'b0, wa3} < c_REGNUM);
    assign w_iss_ok = iss_valid & w_idle & ({1'b0, iss_rd} < c_REGNUM);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign clr_busy = (r_state == S_CLEAR);
    assign clr_done = r_done;

    // ------------------------------------------------------------------
    // Storage and scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REGNUM; r++) begin
                r_mem[r] <= '0;
            end
            r_pending <= '0;
        end else if (r_state == S_CLEAR) begin
            r_mem[r_cnt]     <= '0;
            r_pending[r_cnt] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                for (int l = 0; l < VECTOR_SIZE; l++) begin
                    if (wm3[l]) begin
                        r_mem[wa3][l*DATA_WIDTH +: DATA_WIDTH] <= wd3[l*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                r_pending[wa3] <= 1'b0;
            end
            // Issued after the retire so a same-register collision keeps pending set.
            if (w_iss_ok) begin
                r_pending[iss_rd] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports with lane-wise forwarding
    // ------------------------------------------------------------------
    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;

    for (genvar gp = 0; gp < 2; gp++) begin : g_rport
        logic            w_inr;
        logic            w_fwd;
        logic [c_VW-1:0] w_stored;

        assign w_inr    = ({1'b0, w_ra[gp]} < c_REGNUM);
        assign w_stored = w_inr ? r_mem[w_ra[gp]] : '0;
        assign w_fwd    = w_wr_ok & (wa3 == w_ra[gp]);

        for (genvar gl = 0; gl < VECTOR_SIZE; gl++) begin : g_lane
            assign w_rd[gp][gl*DATA_WIDTH +: DATA_WIDTH] =
                (w_fwd & wm3[gl]) ? wd3[gl*DATA_WIDTH +: DATA_WIDTH]
                                  : w_stored[gl*DATA_WIDTH +: DATA_WIDTH];
        end

        // A retiring write forwards its result, so the register is not busy.
        assign w_busy[gp] = w_inr & r_pending[w_ra[gp]] & ~w_fwd;
    end

    assign rd1   = w_rd[0];
    assign rd2   = w_rd[1];
    assign busy1 = w_busy[0];
    assign busy2 = w_busy[1];

endmodule
`default_nettype wire

// File: tb/tb_vector_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_reg_file_sb
// Brief    : Directed bench for vector_reg_file_sb (16- and 12-register builds).
// Revision : 1.0
// ============================================================================
module tb_vector_reg_file_sb;

    localparam int c_DW = 8;
    localparam int c_VS = 6;
    localparam int c_VW = c_DW * c_VS;
    localparam int c_AW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [c_AW-1:0] ra1 = '0, ra2 = '0, wa3 = '0, iss_rd = '0;
    logic [c_VW-1:0] wd3 = '0;
    logic [c_VS-1:0] wm3 = '0;
    logic            we3 = 1'b0, iss_valid = 1'b0, clr_req = 1'b0;

    logic [c_VW-1:0] rd1, rd2, rd1_b, rd2_b;
    logic            busy1, busy2, clr_busy, clr_done;
    logic            busy1_b, busy2_b, clr_busy_b, clr_done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_reg_file_sb #(.DATA_WIDTH(c_DW), .VECTOR_SIZE(c_VS), .REGNUM(16), .ADDRESSWIDTH(c_AW)) u_dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we3(we3), .wa3(wa3), .wd3(wd3), .wm3(wm3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    vector_reg_file_sb #(.DATA_WIDTH(c_DW), .VECTOR_SIZE(c_VS), .REGNUM(12), .ADDRESSWIDTH(c_AW)) u_dut12 (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .busy1(busy1_b), .busy2(busy2_b), .we3(we3), .wa3(wa3), .wd3(wd3), .wm3(wm3),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .clr_req(clr_req),
        .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    function automatic logic [c_VW-1:0] rep(input logic [c_DW-1:0] b);
        return {c_VS{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        ra1 = 4'd3;
        ra2 = 4'd15;
        #2;
        n_cmp++; if (rd1 !== '0) begin n_err++; $display("FAIL rst_rd1 got %h exp 0", rd1); end
        n_cmp++; if (rd2 !== '0) begin n_err++; $display("FAIL rst_rd2 got %h exp 0", rd2); end
        n_cmp++; if ({busy1, busy2} !== 2'b00) begin n_err++; $display("FAIL rst_busy got %b exp 00", {busy1, busy2}); end
        n_cmp++; if ({clr_busy, clr_done} !== 2'b00) begin n_err++; $display("FAIL rst_clr got %b exp 00", {clr_busy, clr_done}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_masked_forward();
        we3 = 1'b1; wa3 = 4'd5; wd3 = rep(8'hAA); wm3 = 6'h3F; ra1 = 4'd5; ra2 = 4'd5;
        #1;
        n_cmp++; if (rd1 !== rep(8'hAA)) begin n_err++; $display("FAIL fwd_full got %h exp %h", rd1, rep(8'hAA)); end
        step();
        wd3 = rep(8'h11); wm3 = 6'b000101;
        #1;
        n_cmp++; if (rd1 !== 48'hAAAAAA11AA11) begin n_err++; $display("FAIL fwd_mask_rd1 got %h exp aaaaaa11aa11", rd1); end
        n_cmp++; if (rd2 !== 48'hAAAAAA11AA11) begin n_err++; $display("FAIL fwd_mask_rd2 got %h exp aaaaaa11aa11", rd2); end
        step();
        we3 = 1'b0; wd3 = '0; wm3 = '0;
        #1;
        n_cmp++; if (rd1 !== 48'hAAAAAA11AA11) begin n_err++; $display("FAIL mask_stored got %h exp aaaaaa11aa11", rd1); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 4'd7; ra1 = 4'd7; ra2 = 4'd6;
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sb_pre got %b exp 0", busy1); end
        step();
        iss_valid = 1'b0;
        #1;
        n_cmp++; if ({busy1, busy2} !== 2'b10) begin n_err++; $display("FAIL sb_set got %b exp 10", {busy1, busy2}); end
        we3 = 1'b1; wa3 = 4'd7; wm3 = '0; wd3 = rep(8'h55);
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sb_retire_same got %b exp 0", busy1); end
        n_cmp++; if (rd1 !== '0) begin n_err++; $display("FAIL sb_nomask_fwd got %h exp 0", rd1); end
        step();
        we3 = 1'b0;
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sb_retired got %b exp 0", busy1); end
        n_cmp++; if (rd1 !== '0) begin n_err++; $display("FAIL sb_nomask_store got %h exp 0", rd1); end
        iss_valid = 1'b1; iss_rd = 4'd7;
        step();
        iss_valid = 1'b1; iss_rd = 4'd7; we3 = 1'b1; wa3 = 4'd7; wm3 = '0;
        step();
        iss_valid = 1'b0; we3 = 1'b0;
        #1;
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sb_set_wins got %b exp 1", busy1); end
        we3 = 1'b1; wa3 = 4'd7;
        step();
        we3 = 1'b0;
        #1;
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL sb_final_retire got %b exp 0", busy1); end
    endtask

    task automatic test_bulk_clear();
        int busy_cnt;
        int done_seen;
        for (int i = 0; i < 16; i++) begin
            we3 = 1'b1; wa3 = 4'(i); wd3 = rep(8'(8'h20 + i)); wm3 = 6'h3F;
            step();
        end
        we3 = 1'b0; iss_valid = 1'b1; iss_rd = 4'd2;
        step();
        iss_valid = 1'b0; ra1 = 4'd9; ra2 = 4'd2;
        #1;
        n_cmp++; if (rd1 !== rep(8'h29)) begin n_err++; $display("FAIL fill_r9 got %h exp %h", rd1, rep(8'h29)); end
        n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL fill_pend_r2 got %b exp 1", busy2); end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt  = 0;
        done_seen = 0;
        for (int k = 0; k < 40 && clr_busy; k++) begin
            busy_cnt++;
            if (clr_done) done_seen++;
            if (k == 4) begin
                we3 = 1'b1; wa3 = 4'd9; wd3 = rep(8'hFF); wm3 = 6'h3F;
                iss_valid = 1'b1; iss_rd = 4'd10;
                #1;
                n_cmp++; if (rd1 !== rep(8'h29)) begin n_err++; $display("FAIL clr_nofwd got %h exp %h", rd1, rep(8'h29)); end
                n_cmp++; if ({rd2 == '0, busy2} !== 2'b10) begin n_err++; $display("FAIL clr_partial_r2 got rd2=%h busy=%b exp 0/0", rd2, busy2); end
            end
            if (k == 5) begin
                we3 = 1'b0; iss_valid = 1'b0;
                #1;
                n_cmp++; if (rd1 !== rep(8'h29)) begin n_err++; $display("FAIL clr_drop_wr got %h exp %h", rd1, rep(8'h29)); end
            end
            step();
        end
        n_cmp++; if (busy_cnt !== 16) begin n_err++; $display("FAIL clr_len got %0d exp 16", busy_cnt); end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL clr_early_done got %0d exp 0", done_seen); end
        n_cmp++; if ({clr_busy, clr_done} !== 2'b01) begin n_err++; $display("FAIL clr_done_pulse got %b exp 01", {clr_busy, clr_done}); end
        step();
        n_cmp++; if ({clr_busy, clr_done} !== 2'b00) begin n_err++; $display("FAIL clr_done_once got %b exp 00", {clr_busy, clr_done}); end
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i); ra2 = 4'(15 - i);
            #1;
            n_cmp++; if ({rd1, busy1} !== '0) begin n_err++; $display("FAIL clr_zero r%0d got %h busy %b exp 0", i, rd1, busy1); end
            n_cmp++; if ({rd2, busy2} !== '0) begin n_err++; $display("FAIL clr_zero2 r%0d got %h busy %b exp 0", 15 - i, rd2, busy2); end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic bad;
        we3 = 1'b1; wa3 = 4'd12; wd3 = rep(8'hC3); wm3 = 6'h3F;
        step();
        we3 = 1'b0; iss_valid = 1'b1; iss_rd = 4'd12;
        step();
        iss_valid = 1'b0; ra1 = 4'd12;
        #1;
        n_cmp++; if ({rd1, busy1} !== {rep(8'hC3), 1'b1}) begin n_err++; $display("FAIL mid_pre got %h busy %b exp %h/1", rd1, busy1, rep(8'hC3)); end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (6) step();
        n_cmp++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL mid_inclear got %b exp 1", clr_busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({clr_busy, clr_done} !== 2'b00) begin n_err++; $display("FAIL mid_rst_clr got %b exp 00", {clr_busy, clr_done}); end
        n_cmp++; if ({rd1, busy1} !== '0) begin n_err++; $display("FAIL mid_rst_r12 got %h busy %b exp 0", rd1, busy1); end
        step();
        step();
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (clr_done || clr_busy) bad = 1'b1;
            step();
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL mid_no_done got %b exp 0", bad); end
    endtask

    task automatic test_out_of_range();
        we3 = 1'b1; wa3 = 4'd1; wd3 = rep(8'h5A); wm3 = 6'h3F;
        step();
        wa3 = 4'd13; wd3 = rep(8'h77); iss_valid = 1'b1; iss_rd = 4'd13; ra1 = 4'd13; ra2 = 4'd1;
        #1;
        n_cmp++; if ({rd1_b, busy1_b} !== '0) begin n_err++; $display("FAIL oor_fwd got %h busy %b exp 0", rd1_b, busy1_b); end
        n_cmp++; if (rd1 !== rep(8'h77)) begin n_err++; $display("FAIL oor_big_fwd got %h exp %h", rd1, rep(8'h77)); end
        step();
        we3 = 1'b0; iss_valid = 1'b0;
        #1;
        n_cmp++; if ({rd1_b, busy1_b} !== '0) begin n_err++; $display("FAIL oor_read got %h busy %b exp 0", rd1_b, busy1_b); end
        for (int i = 0; i < 12; i++) begin
            ra2 = 4'(i);
            #1;
            n_cmp++;
            if (rd2_b !== ((i == 1) ? rep(8'h5A) : '0)) begin
                n_err++; $display("FAIL oor_untouched r%0d got %h", i, rd2_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_masked_forward();
        test_scoreboard();
        test_bulk_clear();
        test_reset_mid_clear();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
